// File: rtl/riscv_pkg.sv
// Shared decode/execute types: the control bundle carried down the pipe and its bubble encoding.
package riscv_pkg;

    localparam logic [2:0] DMEM_WORD = 3'b100;
    localparam logic [2:0] R_NONE    = 3'b000;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       ALUsrc;
        logic       Branch;
        logic       Jump;
        logic [3:0] ALUControl;
        logic [2:0] R_size;
        logic [2:0] DMem_size;
        logic       jalr;
        logic       lui;
        logic       load_ext_s;
        logic [2:0] funct3;
    } ctrl_t;

    // Idle decoder encoding: nothing written, nothing redirected, load size parked at word.
    localparam ctrl_t CTRL_BUBBLE = '{
        RegWrite:   1'b0,
        ResultSrc:  2'b00,
        MemWrite:   1'b0,
        ALUsrc:     1'b0,
        Branch:     1'b0,
        Jump:       1'b0,
        ALUControl: 4'b0000,
        R_size:     R_NONE,
        DMem_size:  DMEM_WORD,
        jalr:       1'b0,
        lui:        1'b0,
        load_ext_s: 1'b0,
        funct3:     3'b000
    };

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with hold enable, synchronous clear-to-reset-value and async reset.
module pipe_reg #(
    parameter int unsigned      Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_d, q_q;

    // Clear wins over enable so a flush still lands while the stage is stalled.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = ResetVal;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= ResetVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/decode_execute_reg.sv
// D->E pipeline register: control bundle + valid, datapath bundle, and a saturating bubble counter.
module decode_execute_reg
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  ALUsrcD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic [3:0]            ALUControlD,
    input  logic [2:0]            R_sizeD,
    input  logic [2:0]            DMem_sizeD,
    input  logic                  jalrD,
    input  logic                  luiD,
    input  logic                  load_ext_sD,
    input  logic [2:0]            funct3D,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [REG_AW-1:0]     RdD,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic [1:0]            ResultSrcE,
    output logic                  MemWriteE,
    output logic                  ALUsrcE,
    output logic                  BranchE,
    output logic                  JumpE,
    output logic [3:0]            ALUControlE,
    output logic [2:0]            R_sizeE,
    output logic [2:0]            DMem_sizeE,
    output logic                  jalrE,
    output logic                  luiE,
    output logic                  load_ext_sE,
    output logic [2:0]            funct3E,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [REG_AW-1:0]     RdE,
    output logic [REG_AW-1:0]     Rs1E,
    output logic [REG_AW-1:0]     Rs2E,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    localparam int unsigned CtrlW = $bits(ctrl_t) + 1;
    localparam int unsigned DataW = 5 * DATA_WIDTH + 3 * REG_AW;
    localparam logic [CtrlW-1:0] CtrlReset = {CTRL_BUBBLE, 1'b0};

    ctrl_t              ctrl_d;
    ctrl_t              ctrl_q;
    logic [CtrlW-1:0]   ctrl_bundle_q;
    logic [DataW-1:0]   data_d;
    logic [DataW-1:0]   data_q;
    logic               load_en;
    logic               bubble_in;
    logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.RegWrite   = RegWriteD;
        ctrl_d.ResultSrc  = ResultSrcD;
        ctrl_d.MemWrite   = MemWriteD;
        ctrl_d.ALUsrc     = ALUsrcD;
        ctrl_d.Branch     = BranchD;
        ctrl_d.Jump       = JumpD;
        ctrl_d.ALUControl = ALUControlD;
        ctrl_d.R_size     = R_sizeD;
        ctrl_d.DMem_size  = DMem_sizeD;
        ctrl_d.jalr       = jalrD;
        ctrl_d.lui        = luiD;
        ctrl_d.load_ext_s = load_ext_sD;
        ctrl_d.funct3     = funct3D;
    end

    assign data_d = {RD1D, RD2D, PCD, PCPlus4D, ImmExtD, RdD, Rs1D, Rs2D};

    // An invalid decode slot is loaded as a full bubble, so E side effects always need ValidE.
    always_comb begin
        load_en   = ~StallE;
        bubble_in = FlushE | (~StallE & ~ValidD);
    end

    pipe_reg #(
        .Width    (CtrlW),
        .ResetVal (CtrlReset)
    ) u_ctrl_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (load_en),
        .clr_i  (bubble_in),
        .d_i    ({ctrl_d, ValidD}),
        .q_o    (ctrl_bundle_q)
    );

    pipe_reg #(
        .Width    (DataW),
        .ResetVal ('0)
    ) u_data_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (load_en),
        .clr_i  (bubble_in),
        .d_i    (data_d),
        .q_o    (data_q)
    );

    assign ctrl_q = ctrl_t'(ctrl_bundle_q[CtrlW-1:1]);
    assign ValidE = ctrl_bundle_q[0];

    assign RegWriteE   = ctrl_q.RegWrite;
    assign ResultSrcE  = ctrl_q.ResultSrc;
    assign MemWriteE   = ctrl_q.MemWrite;
    assign ALUsrcE     = ctrl_q.ALUsrc;
    assign BranchE     = ctrl_q.Branch;
    assign JumpE       = ctrl_q.Jump;
    assign ALUControlE = ctrl_q.ALUControl;
    assign R_sizeE     = ctrl_q.R_size;
    assign DMem_sizeE  = ctrl_q.DMem_size;
    assign jalrE       = ctrl_q.jalr;
    assign luiE        = ctrl_q.lui;
    assign load_ext_sE = ctrl_q.load_ext_s;
    assign funct3E     = ctrl_q.funct3;

    assign {RD1E, RD2E, PCE, PCPlus4E, ImmExtE, RdE, Rs1E, Rs2E} = data_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_in && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule
